dmem_dump_reader: RTL

Read side of the data-memory debug path: on command from the C2 controller, walks the data-memory range recorded by the core's write tracker and reads it through the BRAM's read-only port B. Serialises the range as a length-prefixed little-endian byte stream into the UART transmit path. It pairs with the loader, which writes memory through port A.

---
 rtl/dmem_dump_reader_if.sv | 30 +++
 rtl/dmem_dump_reader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dmem_dump_reader_if.sv
// Command, BRAM port B and byte-stream signals of the data-memory dump reader.
// master is the reader itself; slave is the controller/BRAM/UART side.
interface dmem_dump_reader_if;
  logic        start_i;
  logic        abort_i;
  logic [31:0] min_addr_i;
  logic [31:0] max_addr_i;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        done_o;

  modport master (
    input  start_i, abort_i, min_addr_i, max_addr_i,
    input  mem_rdata_i, tx_ready_i,
    output mem_en_o, mem_addr_o, tx_data_o, tx_valid_o,
    output busy_o, done_o
  );

  modport slave (
    output start_i, abort_i, min_addr_i, max_addr_i,
    output mem_rdata_i, tx_ready_i,
    input  mem_en_o, mem_addr_o, tx_data_o, tx_valid_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/dmem_dump_reader.sv
// Walks the tracked data-memory range over BRAM port B and streams it as a
// length-prefixed little-endian byte sequence.
module dmem_dump_reader #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input logic                clk_i,
  input logic                rst_i,
  dmem_dump_reader_if.master bus
);

  localparam logic [31:0] TOP = 32'(MEM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, RD_REQ, RD_WAIT, SEND, FIN
  } state_t;

  state_t      state;
  logic [31:0] addr;
  logic [31:0] remain;
  logic [31:0] cnt;
  logic [31:0] word;
  logic [1:0]  idx;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  logic [31:0] s_base;
  logic [31:0] s_max;
  logic [31:0] s_last;
  logic [31:0] s_cnt;
  logic        accept;

  assign bus.mem_en_o   = mem_en;
  assign bus.mem_addr_o = mem_addr;
  assign bus.tx_data_o  = tx_data;
  assign bus.tx_valid_o = tx_valid;
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;

  assign accept = tx_valid && bus.tx_ready_i;

  // Range is clamped to the top word of memory, so the walk never wraps.
  always_comb begin
    s_base = bus.min_addr_i & ~32'd3;
    s_max  = (bus.max_addr_i > TOP) ? TOP : bus.max_addr_i;
    s_last = s_max & ~32'd3;
    s_cnt  = '0;
    if (!(bus.min_addr_i > bus.max_addr_i || s_base > s_last))
      s_cnt = ((s_last - s_base) >> 2) + 32'd1;
  end

  function automatic logic [7:0] pick(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    return w[8*i +: 8];
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      addr     <= '0;
      remain   <= '0;
      cnt      <= '0;
      word     <= '0;
      idx      <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && bus.abort_i) begin
        state    <= IDLE;
        idx      <= '0;
        mem_en   <= 1'b0;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start_i) begin
              addr     <= s_base;
              remain   <= s_cnt;
              cnt      <= s_cnt;
              idx      <= '0;
              tx_data  <= s_cnt[7:0];
              tx_valid <= 1'b1;
              busy     <= 1'b1;
              state    <= HDR;
            end
          end
          HDR: begin
            if (accept) begin
              idx <= idx + 2'd1;
              if (idx == 2'd3) begin
                tx_valid <= 1'b0;
                if (remain != '0) begin
                  state    <= RD_REQ;
                  mem_en   <= 1'b1;
                  mem_addr <= addr;
                end else begin
                  state <= FIN;
                  done  <= 1'b1;
                end
              end else begin
                tx_data <= pick(cnt, idx + 2'd1);
              end
            end
          end
          RD_REQ: state <= RD_WAIT;
          RD_WAIT: begin
            word     <= bus.mem_rdata_i;
            tx_data  <= bus.mem_rdata_i[7:0];
            tx_valid <= 1'b1;
            mem_en   <= 1'b0;
            idx      <= '0;
            state    <= SEND;
          end
          SEND: begin
            if (accept) begin
              idx <= idx + 2'd1;
              if (idx == 2'd3) begin
                tx_valid <= 1'b0;
                addr     <= addr + 32'd4;
                remain   <= remain - 32'd1;
                if (remain != 32'd1) begin
                  state    <= RD_REQ;
                  mem_en   <= 1'b1;
                  mem_addr <= addr + 32'd4;
                end else begin
                  state <= FIN;
                  done  <= 1'b1;
                end
              end else begin
                tx_data <= pick(word, idx + 2'd1);
              end
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
